// File: rtl/alu_cmd_issuer.sv
// Command issuer for the add/subtract ALU: buffers commands in a FIFO, drives the ALU,
// waits a settle time, then offers the captured result/carry over valid/ready.
module alu_cmd_issuer #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [WIDTH-1:0] cmd_a_i,
    input  logic [WIDTH-1:0] cmd_b_i,
    input  logic             cmd_add_i,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic             alu_s_o,
    input  logic [WIDTH-1:0] alu_q_i,
    input  logic             alu_c_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_q_o,
    output logic             rsp_c_o,
    output logic             busy_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned EntW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StResp
    } state_e;

    logic [EntW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            full, empty, push, pop;
    logic [EntW-1:0] head;

    state_e          state_q, state_d;
    logic [2:0]      settle_q, settle_d;
    logic            load, capture;

    logic [WIDTH-1:0] alu_a_q, alu_b_q, rsp_q_q;
    logic             alu_s_q, rsp_c_q, rsp_valid_q, rsp_valid_d;

    assign full        = (count_q == CntW'(DEPTH));
    assign empty       = (count_q == '0);
    // Ready depends only on occupancy (and reset), never on the FSM.
    assign cmd_ready_o = !full && !rst_i;
    assign push        = cmd_valid_i && cmd_ready_o;
    assign head        = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_a_i, cmd_b_i, cmd_add_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        rsp_valid_d = rsp_valid_q;
        pop         = 1'b0;
        load        = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                if (settle_q == 3'd1) begin
                    capture     = 1'b1;
                    rsp_valid_d = 1'b1;
                    settle_d    = 3'd0;
                    state_d     = StResp;
                end else begin
                    settle_d = settle_q - 3'd1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    // Back-to-back issue: skip IDLE when work is already queued.
                    if (!empty) begin
                        pop     = 1'b1;
                        load    = 1'b1;
                        state_d = StDrive;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            settle_d = 3'(SETTLE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            settle_q    <= 3'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q_q     <= '0;
            rsp_c_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            rsp_valid_q <= rsp_valid_d;
            if (load) begin
                alu_a_q <= head[EntW-1 -: WIDTH];
                alu_b_q <= head[WIDTH -: WIDTH];
                alu_s_q <= head[0];
            end
            if (capture) begin
                rsp_q_q <= alu_q_i;
                rsp_c_q <= alu_c_i;
            end
        end
    end

    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_s_o     = alu_s_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_q_o     = rsp_q_q;
    assign rsp_c_o     = rsp_c_q;
    assign busy_o      = (state_q != StIdle) || !empty;

endmodule
